// File: rtl/seg_label_out_pkg.sv
// Shared fixed-point format constants and helpers for the segmentation
// pipeline back-end and the layer modules.
package seg_label_out_pkg;

    // Default fixed-point score format: sign-inclusive integer bits and fraction bits
    localparam int FIXED_INT_BITW  = 5;
    localparam int FIXED_FRAC_BITW = 8;

    // Number of class scores per pixel and the width of a class index
    localparam int UNIT_NUM   = 4;
    localparam int LABEL_BITW = 2;

    // Histogram synchroniser states
    typedef enum logic {
        UNSYNC,
        COUNT
    } hist_state_t;

    // Bits needed to hold the values 0 .. value-1; never less than one bit
    function automatic int log2(input int value);
        int bits;
        int rest;
        bits = 0;
        if (value <= 1) begin
            return 1;
        end
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seg_label_out_delay.sv
// Fixed-latency register chain used to keep side-band data aligned with a
// pipelined datapath.
module delay
    import seg_label_out_pkg::*;
#(
    parameter int BIT_WIDTH = 1,
    parameter int LATENCY   = 1
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [BIT_WIDTH-1:0] out_data
);

    logic [BIT_WIDTH-1:0] stages [LATENCY];

    // Shift the input through LATENCY registers, cleared on reset
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_data = stages[LATENCY-1];

endmodule

// File: rtl/seg_label_out_fixed_to_uint.sv
// Combinational conversion of a signed fixed-point score into an unsigned
// confidence: negatives clamp to zero, large values saturate, and narrower
// outputs are rounded half-up from the fraction.
module fixed_to_uint
    import seg_label_out_pkg::*;
#(
    parameter int INT_BITW   = FIXED_INT_BITW,
    parameter int FRAC_BITW  = FIXED_FRAC_BITW,
    parameter int UINT_BITW  = 8,
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW
) (
    input  logic [FIXED_BITW-1:0] score,
    output logic [UINT_BITW-1:0]  conf
);

    if (UINT_BITW == FRAC_BITW) begin : g_direct
        // Output is the raw fraction; any integer bit set means the value is >= 1.0
        always_comb begin
            conf = '0;
            if (score[FIXED_BITW-1]) begin
                conf = '0;
            end else if (score[FIXED_BITW-1:FRAC_BITW] != '0) begin
                conf = '1;
            end else begin
                conf = score[UINT_BITW-1:0];
            end
        end
    end else begin : g_round
        localparam int SHIFT = FRAC_BITW - UINT_BITW - 1;

        logic [FIXED_BITW-1:0] shifted;
        logic [FIXED_BITW:0]   rounded;

        // Keep one guard bit, add half an LSB, drop the guard bit, then saturate
        always_comb begin
            shifted = score >> SHIFT;
            rounded = ({1'b0, shifted} + (FIXED_BITW + 1)'(1)) >> 1;
            conf    = '0;
            if (score[FIXED_BITW-1]) begin
                conf = '0;
            end else if (rounded[FIXED_BITW:UINT_BITW] != '0) begin
                conf = '1;
            end else begin
                conf = rounded[UINT_BITW-1:0];
            end
        end
    end

endmodule

// File: rtl/seg_label_out.sv
// Segmentation back-end: per-pixel argmax over four fixed-point class scores
// with a uint confidence, coordinates delayed to match, and a per-frame class
// histogram published at the last raster position of each frame.
module seg_label_out
    import seg_label_out_pkg::*;
#(
    parameter int HEIGHT    = -1,
    parameter int WIDTH     = -1,
    parameter int W_HEIGHT  = -1,
    parameter int W_WIDTH   = -1,
    parameter int UINT_BITW = 8,
    parameter int INT_BITW  = FIXED_INT_BITW,
    parameter int FRAC_BITW = FIXED_FRAC_BITW,
    localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
    localparam int V_BITW     = log2(W_HEIGHT),
    localparam int H_BITW     = log2(W_WIDTH),
    localparam int CNT_BITW   = log2(W_HEIGHT * W_WIDTH + 1)
) (
    input  logic                             clock,
    input  logic                             n_rst,
    input  logic [0:FIXED_BITW*UNIT_NUM-1]   in_pixels,
    input  logic [V_BITW-1:0]                in_vcnt,
    input  logic [H_BITW-1:0]                in_hcnt,
    output logic [LABEL_BITW-1:0]            out_label,
    output logic [UINT_BITW-1:0]             out_conf,
    output logic [V_BITW-1:0]                out_vcnt,
    output logic [H_BITW-1:0]                out_hcnt,
    output logic [0:CNT_BITW*UNIT_NUM-1]     out_hist,
    output logic                             out_hist_valid
);

    localparam logic [V_BITW-1:0] LAST_V = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] LAST_H = H_BITW'(W_WIDTH - 1);

    // HEIGHT/WIDTH only describe the visible image; the raster bounds drive the
    // logic. A visible image larger than the raster elaborates this marker block.
    if ((HEIGHT > W_HEIGHT) || (WIDTH > W_WIDTH)) begin : g_geometry_exceeds_raster
    end

    logic signed [FIXED_BITW-1:0] score [UNIT_NUM];

    logic signed [FIXED_BITW-1:0] m01_score;
    logic signed [FIXED_BITW-1:0] m23_score;
    logic [LABEL_BITW-1:0]        m01_idx;
    logic [LABEL_BITW-1:0]        m23_idx;

    logic signed [FIXED_BITW-1:0] s2_score;
    logic [LABEL_BITW-1:0]        s2_label;

    logic [UINT_BITW-1:0]         conf_next;
    logic [2:0]                   fill;
    logic                         primed;

    logic [V_BITW+H_BITW-1:0]     coord_out;

    hist_state_t                  state;
    logic [CNT_BITW-1:0]          cnt       [UNIT_NUM];
    logic [CNT_BITW-1:0]          label_hit [UNIT_NUM];
    logic                         first_pixel;
    logic                         last_pixel;

    for (genvar k = 0; k < UNIT_NUM; k++) begin : g_unit
        assign score[k] = in_pixels[k*FIXED_BITW +: FIXED_BITW];
    end

    // Stage 1: pairwise maxima; strict compare keeps the lower index on ties
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            m01_score <= '0;
            m01_idx   <= '0;
            m23_score <= '0;
            m23_idx   <= '0;
        end else begin
            if (score[1] > score[0]) begin
                m01_score <= score[1];
                m01_idx   <= LABEL_BITW'(1);
            end else begin
                m01_score <= score[0];
                m01_idx   <= LABEL_BITW'(0);
            end
            if (score[3] > score[2]) begin
                m23_score <= score[3];
                m23_idx   <= LABEL_BITW'(3);
            end else begin
                m23_score <= score[2];
                m23_idx   <= LABEL_BITW'(2);
            end
        end
    end

    // Stage 2: final maximum; the upper pair must be strictly larger to win
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            s2_score <= '0;
            s2_label <= '0;
        end else if (m23_score > m01_score) begin
            s2_score <= m23_score;
            s2_label <= m23_idx;
        end else begin
            s2_score <= m01_score;
            s2_label <= m01_idx;
        end
    end

    fixed_to_uint #(
        .INT_BITW  (INT_BITW),
        .FRAC_BITW (FRAC_BITW),
        .UINT_BITW (UINT_BITW)
    ) u_conf (
        .score (s2_score),
        .conf  (conf_next)
    );

    // Stage 3: register the label and the converted confidence
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_label <= '0;
            out_conf  <= '0;
        end else begin
            out_label <= s2_label;
            out_conf  <= conf_next;
        end
    end

    delay #(
        .BIT_WIDTH (V_BITW + H_BITW),
        .LATENCY   (3)
    ) u_coord_delay (
        .clock    (clock),
        .n_rst    (n_rst),
        .in_data  ({in_vcnt, in_hcnt}),
        .out_data (coord_out)
    );

    assign {out_vcnt, out_hcnt} = coord_out;

    // Fill marker: all ones once real pixels have reached the output registers
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            fill <= '0;
        end else begin
            fill <= {fill[1:0], 1'b1};
        end
    end

    assign primed      = fill[2];
    assign first_pixel = (out_vcnt == '0) && (out_hcnt == '0);
    assign last_pixel  = (out_vcnt == LAST_V) && (out_hcnt == LAST_H);

    // One-hot increment vector for the class currently at the output
    always_comb begin
        for (int k = 0; k < UNIT_NUM; k++) begin
            label_hit[k] = (out_label == LABEL_BITW'(k)) ? CNT_BITW'(1) : '0;
        end
    end

    // Histogram FSM: wait for a frame start, then count and publish every frame
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state          <= UNSYNC;
            out_hist       <= '0;
            out_hist_valid <= 1'b0;
            for (int k = 0; k < UNIT_NUM; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            out_hist_valid <= 1'b0;
            case (state)
                UNSYNC: begin
                    if (primed && first_pixel) begin
                        state <= COUNT;
                        for (int k = 0; k < UNIT_NUM; k++) begin
                            cnt[k] <= label_hit[k];
                        end
                    end
                end
                COUNT: begin
                    if (last_pixel) begin
                        out_hist_valid <= 1'b1;
                        for (int k = 0; k < UNIT_NUM; k++) begin
                            out_hist[k*CNT_BITW +: CNT_BITW] <= cnt[k] + label_hit[k];
                            cnt[k] <= '0;
                        end
                    end else begin
                        for (int k = 0; k < UNIT_NUM; k++) begin
                            cnt[k] <= cnt[k] + label_hit[k];
                        end
                    end
                end
                default: begin
                    state <= UNSYNC;
                end
            endcase
        end
    end

endmodule
